jtcop_sec_mbx: RTL and testbench

- MCU-side end of the main CPU "SEC" security/sub-CPU link.
- Main CPU side:
  - Command word arrives on the main data bus; the main write strobe (sec[0]) latches it.
  - Main reads the reply word through a read strobe (sec[1]).
  - The block raises the sec2 interrupt line, which the main CPU edge-detects.
- MCU side: an 8-bit register window with an interrupt output tells the sub CPU a command is waiting.

---
 rtl/jtcop_sec_mbx_pkg.sv | 21 ++
 rtl/jtcop_sec_mbx_pulse.sv | 69 ++++++
 rtl/jtcop_sec_mbx.sv | 120 ++++++++++++
 tb/tb_jtcop_sec_mbx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtcop_sec_mbx_pkg.sv
// Shared definitions for the SEC mailbox: register map, status bits
// and sec2 pulse FSM encoding.
package jtcop_sec_mbx_pkg;

  localparam logic [2:0] REG_CMDL = 3'd0;
  localparam logic [2:0] REG_CMDH = 3'd1;
  localparam logic [2:0] REG_RPLL = 3'd2;
  localparam logic [2:0] REG_RPLH = 3'd3;
  localparam logic [2:0] REG_STAT = 3'd4;

  localparam int ST_PEND = 0;
  localparam int ST_UNRD = 1;
  localparam int ST_OVR  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } pulse_st_t;

endpackage

// File: rtl/jtcop_sec_mbx_pulse.sv
// sec2 pulse generator: fixed-width high pulse, minimum low gap,
// commits during a pulse collapse into one retrigger.
module jtcop_sec_pulse
  import jtcop_sec_mbx_pkg::*;
#(
  parameter int IRQ_LEN = 8,
  parameter int GAP_LEN = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic trig,
  output logic sec2
);

  localparam logic [7:0] HI_LD = 8'(IRQ_LEN - 1);
  localparam logic [7:0] GP_LD = 8'(GAP_LEN - 1);

  pulse_st_t  st;
  logic [7:0] cnt;
  logic       retrig;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st     <= IDLE;
      cnt    <= 8'd0;
      retrig <= 1'b0;
      sec2   <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (trig) begin
            st   <= HIGH;
            cnt  <= HI_LD;
            sec2 <= 1'b1;
          end
        end
        HIGH: begin
          if (trig) retrig <= 1'b1;
          if (cnt == 8'd0) begin
            st   <= GAP;
            cnt  <= GP_LD;
            sec2 <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GAP: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
            if (trig) retrig <= 1'b1;
          end else if (retrig || trig) begin
            // a commit landing on the last gap cycle is consumed here
            st     <= HIGH;
            cnt    <= HI_LD;
            retrig <= 1'b0;
            sec2   <= 1'b1;
          end else begin
            st <= IDLE;
          end
        end
        default: begin
          st   <= IDLE;
          sec2 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/jtcop_sec_mbx.sv
// MCU-side SEC mailbox: command latch, reply word, sec2 pulse.
// Optional overrun flag enabled by JTCOP_SEC_MBX_OVR_EN.
module jtcop_sec_mbx
  import jtcop_sec_mbx_pkg::*;
#(
  parameter int IRQ_LEN = 8,
  parameter int GAP_LEN = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] main_din,
  input  logic        main_wr,
  input  logic        main_rd,
  output logic [15:0] main_dout,
  output logic        sec2,
  input  logic        mcu_cs,
  input  logic        mcu_we,
  input  logic [2:0]  mcu_addr,
  input  logic [7:0]  mcu_din,
  output logic [7:0]  mcu_dout,
  output logic        mcu_irq
);

  logic [15:0] cmd;
  logic [7:0]  reply_lo;
  logic [7:0]  stat;
  logic        cmd_pend;
  logic        reply_unread;
  logic        ovr;
  logic        main_wr_l;
  logic        main_rd_l;
  logic        wr_edge;
  logic        rd_edge;
  logic        acc_wr;
  logic        acc_rd;
  logic        commit;
  logic        stat_wr;
  logic        clr_pend;

  assign wr_edge  = main_wr & ~main_wr_l;
  assign rd_edge  = main_rd & ~main_rd_l;
  assign acc_wr   = mcu_cs & mcu_we;
  assign acc_rd   = mcu_cs & ~mcu_we;
  assign commit   = acc_wr && mcu_addr == REG_RPLH;
  assign stat_wr  = acc_wr && mcu_addr == REG_STAT;
  assign clr_pend = (acc_rd && mcu_addr == REG_CMDH)
                  | (stat_wr & mcu_din[0]);

  always_comb begin
    stat          = 8'd0;
    stat[ST_PEND] = cmd_pend;
    stat[ST_UNRD] = reply_unread;
    stat[ST_OVR]  = ovr;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      main_wr_l    <= 1'b0;
      main_rd_l    <= 1'b0;
      cmd          <= 16'd0;
      cmd_pend     <= 1'b0;
      reply_lo     <= 8'd0;
      reply_unread <= 1'b0;
      main_dout    <= 16'd0;
      mcu_dout     <= 8'hff;
      mcu_irq      <= 1'b0;
    end else begin
      main_wr_l <= main_wr;
      main_rd_l <= main_rd;
      mcu_irq   <= cmd_pend;
      // a new command beats a same-cycle MCU clear
      if (wr_edge) begin
        cmd      <= main_din;
        cmd_pend <= 1'b1;
      end else if (clr_pend) begin
        cmd_pend <= 1'b0;
      end
      if (acc_wr && mcu_addr == REG_RPLL) reply_lo <= mcu_din;
      if (commit) begin
        main_dout    <= {mcu_din, reply_lo};
        reply_unread <= 1'b1;
      end else if (rd_edge) begin
        reply_unread <= 1'b0;
      end
      if (acc_rd) begin
        unique case (1'b1)
          mcu_addr == REG_CMDL: mcu_dout <= cmd[7:0];
          mcu_addr == REG_CMDH: mcu_dout <= cmd[15:8];
          mcu_addr == REG_STAT: mcu_dout <= stat;
          default:              mcu_dout <= 8'hff;
        endcase
      end
    end
  end

`ifdef JTCOP_SEC_MBX_OVR_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovr <= 1'b0;
    end else if (wr_edge && cmd_pend) begin
      ovr <= 1'b1;
    end else if (stat_wr && mcu_din[ST_OVR]) begin
      ovr <= 1'b0;
    end
  end
`else
  assign ovr = 1'b0;
`endif

  jtcop_sec_pulse #(
    .IRQ_LEN (IRQ_LEN),
    .GAP_LEN (GAP_LEN)
  ) u_pulse (
    .clk  (clk),
    .rstn (rstn),
    .trig (commit),
    .sec2 (sec2)
  );

endmodule

// File: tb/tb_jtcop_sec_mbx.sv
// Self-checking bench for jtcop_sec_mbx: vector table, scoreboard of
// expected MCU reads, and hand sequences for pulse/race/reset cases.
module tb_jtcop_sec_mbx;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] main_din;
  logic        main_wr;
  logic        main_rd;
  logic [15:0] main_dout;
  logic        sec2;
  logic        mcu_cs;
  logic        mcu_we;
  logic [2:0]  mcu_addr;
  logic [7:0]  mcu_din;
  logic [7:0]  mcu_dout;
  logic        mcu_irq;

  int n_pass = 0;
  int n_tot  = 0;

  logic [7:0] sb[$];

  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;
  } vec_t;

  vec_t tv[8];

  jtcop_sec_mbx dut (
    .clk       (clk),
    .rstn      (rstn),
    .main_din  (main_din),
    .main_wr   (main_wr),
    .main_rd   (main_rd),
    .main_dout (main_dout),
    .sec2      (sec2),
    .mcu_cs    (mcu_cs),
    .mcu_we    (mcu_we),
    .mcu_addr  (mcu_addr),
    .mcu_din   (mcu_din),
    .mcu_dout  (mcu_dout),
    .mcu_irq   (mcu_irq)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic mcu_acc(input logic we, input logic [2:0] addr,
                         input logic [7:0] din, input logic [7:0] exp,
                         input string name);
    logic [7:0] e;
    mcu_cs   = 1'b1;
    mcu_we   = we;
    mcu_addr = addr;
    mcu_din  = din;
    if (!we) sb.push_back(exp);
    cyc();
    mcu_cs = 1'b0;
    mcu_we = 1'b0;
    if (!we) begin
      e = sb.pop_front();
      chk(name, {24'd0, mcu_dout}, {24'd0, e});
    end
  endtask

  task automatic main_pulse_wr(input logic [15:0] d);
    main_din = d;
    main_wr  = 1'b1;
    cyc();
    main_wr = 1'b0;
    cyc();
  endtask

  task automatic main_pulse_rd();
    main_rd = 1'b1;
    cyc();
    main_rd = 1'b0;
    cyc();
  endtask

  initial begin
    logic [29:0] samp;
    logic [29:0] pat;
    logic        prev;
    logic        any;
    int          hi;
    int          rises;

    tv[0] = '{1'b0, 3'd0, 8'h00, 8'h34, 1'b1};
    tv[1] = '{1'b0, 3'd1, 8'h00, 8'h12, 1'b1};
    tv[2] = '{1'b0, 3'd5, 8'h00, 8'hff, 1'b0};
    tv[3] = '{1'b0, 3'd7, 8'h00, 8'hff, 1'b0};
    tv[4] = '{1'b0, 3'd2, 8'h00, 8'hff, 1'b0};
    tv[5] = '{1'b0, 3'd4, 8'h00, 8'h00, 1'b0};
    tv[6] = '{1'b1, 3'd2, 8'hCD, 8'h00, 1'b0};
    tv[7] = '{1'b0, 3'd0, 8'h00, 8'h34, 1'b0};

    rstn = 1'b0; main_din = '0; main_wr = 0; main_rd = 0;
    mcu_cs = 0; mcu_we = 0; mcu_addr = '0; mcu_din = '0;
    cyc(); cyc();
    chk("rst_main_dout", {16'd0, main_dout}, 32'd0);
    chk("rst_sec2", {31'd0, sec2}, 32'd0);
    chk("rst_mcu_dout", {24'd0, mcu_dout}, 32'hff);
    chk("rst_mcu_irq", {31'd0, mcu_irq}, 32'd0);

    // command handoff, write strobe held 4 cycles
    rstn = 1'b1;
    main_din = 16'h1234;
    main_wr = 1'b1;
    cyc();
    chk("irq_lat0", {31'd0, mcu_irq}, 32'd0);
    main_din = 16'h5678;
    cyc();
    chk("irq_lat1", {31'd0, mcu_irq}, 32'd1);
    cyc(); cyc();
    main_wr = 1'b0;

    foreach (tv[i]) begin
      mcu_acc(tv[i].we, tv[i].addr, tv[i].din, tv[i].dout,
              $sformatf("vec%0d_dout", i));
      chk($sformatf("vec%0d_irq", i), {31'd0, mcu_irq},
          {31'd0, tv[i].irq});
    end

    // reply commit and single pulse width
    mcu_acc(1'b1, 3'd3, 8'hAB, 8'h00, "commit");
    chk("reply_word", {16'd0, main_dout}, 32'hABCD);
    chk("sec2_rise", {31'd0, sec2}, 32'd1);
    hi = 1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (!sec2) break;
      hi++;
    end
    chk("sec2_width", hi, 8);
    mcu_acc(1'b0, 3'd4, 8'h00, 8'h02, "stat_unread");
    main_pulse_rd();
    mcu_acc(1'b0, 3'd4, 8'h00, 8'h00, "stat_read_clr");

    // commit and main read edge in one cycle
    main_rd = 1'b1;
    mcu_acc(1'b1, 3'd3, 8'h11, 8'h00, "commit_rd");
    main_rd = 1'b0;
    chk("reply_word2", {16'd0, main_dout}, 32'h11CD);
    mcu_acc(1'b0, 3'd4, 8'h00, 8'h02, "stat_commit_wins");
    for (int i = 0; i < 15; i++) cyc();

    // retrigger three cycles into a pulse
    prev = sec2;
    rises = 0;
    samp = '0;
    pat = '0;
    for (int k = 0; k < 30; k++) begin
      if ((k >= 0 && k <= 7) || (k >= 10 && k <= 17)) pat[k] = 1'b1;
      if (k == 0 || k == 3) begin
        mcu_cs = 1'b1; mcu_we = 1'b1;
        mcu_addr = 3'd3; mcu_din = 8'(k);
      end
      cyc();
      mcu_cs = 1'b0; mcu_we = 1'b0;
      samp[k] = sec2;
      if (sec2 && !prev) rises++;
      prev = sec2;
    end
    chk("retrig_pattern", {2'd0, samp}, {2'd0, pat});
    chk("retrig_rises", rises, 2);

    // main write edge racing an MCU status clear
    main_din = 16'h00AA;
    main_wr = 1'b1;
    mcu_cs = 1'b1; mcu_we = 1'b1; mcu_addr = 3'd4; mcu_din = 8'h01;
    cyc();
    mcu_cs = 1'b0; mcu_we = 1'b0; main_wr = 1'b0;
    cyc();
    chk("race_irq", {31'd0, mcu_irq}, 32'd1);
    mcu_acc(1'b0, 3'd4, 8'h00, 8'h03, "race_stat");
    mcu_acc(1'b0, 3'd0, 8'h00, 8'hAA, "race_cmdl");
    mcu_acc(1'b0, 3'd1, 8'h00, 8'h00, "race_cmdh");
    main_pulse_rd();

    // two main writes with no MCU read in between
    main_pulse_wr(16'h0001);
    main_pulse_wr(16'h0002);
`ifdef JTCOP_SEC_MBX_OVR_EN
    mcu_acc(1'b0, 3'd4, 8'h00, 8'h05, "ovr_stat");
`else
    mcu_acc(1'b0, 3'd4, 8'h00, 8'h01, "ovr_stat");
`endif
    mcu_acc(1'b0, 3'd0, 8'h00, 8'h02, "ovr_cmdl");
    mcu_acc(1'b1, 3'd4, 8'h04, 8'h00, "ovr_clr");
    mcu_acc(1'b0, 3'd4, 8'h00, 8'h01, "ovr_cleared");
    mcu_acc(1'b0, 3'd1, 8'h00, 8'h00, "ovr_cmdh");

    // reset in the middle of a pulse
    mcu_acc(1'b1, 3'd3, 8'h55, 8'h00, "commit_rst");
    cyc(); cyc();
    chk("pre_rst_sec2", {31'd0, sec2}, 32'd1);
    rstn = 1'b0;
    cyc();
    chk("mid_rst_sec2", {31'd0, sec2}, 32'd0);
    chk("mid_rst_main_dout", {16'd0, main_dout}, 32'd0);
    chk("mid_rst_mcu_dout", {24'd0, mcu_dout}, 32'hff);
    chk("mid_rst_irq", {31'd0, mcu_irq}, 32'd0);
    rstn = 1'b1;
    any = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      any = any | sec2;
    end
    chk("post_rst_quiet", {31'd0, any}, 32'd0);
    mcu_acc(1'b0, 3'd4, 8'h00, 8'h00, "post_rst_stat");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
